// File: rtl/axi_bresp_router.sv
// AXI B-channel router: NUM_S slaves to NUM_M masters, round-robin grant, one-deep output slice.
// Define AXI_BRESP_ERRCNT_EN to add the saturating err_cnt output.
//
// state | meaning
// EMPTY | slice holds nothing; any valid slave may be accepted
// FULL  | slice holds one response for master tgt_q; drains on bready_m[tgt_q]
module axi_bresp_router #(
    parameter int NUM_S = 6,
    parameter int NUM_M = 2,
    parameter int ID_W  = 4,
    parameter int IDS_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_S*IDS_W-1:0]  bid_s,
    input  logic [NUM_S*2-1:0]      bresp_s,
    input  logic [NUM_S-1:0]        bvalid_s,
    output logic [NUM_S-1:0]        bready_s,
    output logic [NUM_M*ID_W-1:0]   bid_m,
    output logic [NUM_M*2-1:0]      bresp_m,
    output logic [NUM_M-1:0]        bvalid_m,
    input  logic [NUM_M-1:0]        bready_m,
    output logic                    unroutable
`ifdef AXI_BRESP_ERRCNT_EN
    ,
    output logic [15:0]             err_cnt
`endif
);

    localparam int SW = $clog2(NUM_S);
    localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int TW = IDS_W - ID_W;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]      state_q;
    logic            full_q;
    logic [MW-1:0]   tgt_q;
    logic [ID_W-1:0] bid_q;
    logic [1:0]      bresp_q;
    logic [SW-1:0]   rr_ptr;
    logic            unroutable_q;

    logic [IDS_W-1:0] bid_arr   [NUM_S];
    logic [1:0]       bresp_arr [NUM_S];

    for (genvar k = 0; k < NUM_S; k++) begin : g_unpack
        assign bid_arr[k]   = bid_s[k*IDS_W +: IDS_W];
        assign bresp_arr[k] = bresp_s[k*2 +: 2];
    end

    assign full_q = (state_q == FULL);

    // Round-robin search starting at rr_ptr, wrapping at NUM_S-1.
    logic [SW-1:0] grant;
    logic          found;
    logic [SW:0]   idx_sum;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        idx_sum = '0;
        for (int i = 0; i < NUM_S; i++) begin
            idx_sum = {1'b0, rr_ptr} + (SW+1)'(i);
            if (idx_sum >= (SW+1)'(NUM_S)) begin
                idx_sum = idx_sum - (SW+1)'(NUM_S);
            end
            if (!found && bvalid_s[idx_sum[SW-1:0]]) begin
                found = 1'b1;
                grant = idx_sum[SW-1:0];
            end
        end
    end

    logic [IDS_W-1:0] sel_bid;
    logic [1:0]       sel_bresp;
    logic [TW-1:0]    tag;
    logic             routable;
    logic [MW-1:0]    route_tgt;

    assign sel_bid   = bid_arr[grant];
    assign sel_bresp = bresp_arr[grant];
    assign tag       = sel_bid[IDS_W-1:ID_W];

    always_comb begin
        routable  = 1'b0;
        route_tgt = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (tag == (TW'(1) << m)) begin
                routable  = 1'b1;
                route_tgt = MW'(m);
            end
        end
    end

    logic can_accept;
    logic accept;

    assign can_accept = ~full_q | bready_m[tgt_q];
    // Gated by rst so no slave sees a handshake while the block is held in reset.
    assign accept     = rst & can_accept & found;

    always_comb begin
        bready_s = '0;
        if (accept) begin
            bready_s[grant] = 1'b1;
        end
    end

    always_comb begin
        bvalid_m = '0;
        bid_m    = '0;
        bresp_m  = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (full_q && (tgt_q == MW'(m))) begin
                bvalid_m[m]            = 1'b1;
                bid_m[m*ID_W +: ID_W]  = bid_q;
                bresp_m[m*2 +: 2]      = bresp_q;
            end
        end
    end

    assign unroutable = unroutable_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            tgt_q        <= '0;
            bid_q        <= '0;
            bresp_q      <= '0;
            rr_ptr       <= '0;
            unroutable_q <= 1'b0;
        end else begin
            unroutable_q <= accept & ~routable;
            if (accept) begin
                rr_ptr <= (grant == SW'(NUM_S-1)) ? '0 : grant + 1'b1;
                if (routable) begin
                    state_q <= FULL;
                    tgt_q   <= route_tgt;
                    bid_q   <= sel_bid[ID_W-1:0];
                    bresp_q <= sel_bresp;
                end else begin
                    state_q <= EMPTY;
                end
            end else if (full_q && bready_m[tgt_q]) begin
                state_q <= EMPTY;
            end
        end
    end

`ifdef AXI_BRESP_ERRCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (accept && (sel_bresp[1] || !routable) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_bresp_router.sv
// Scoreboard bench for axi_bresp_router: directed scenarios followed by random traffic.
module tb_axi_bresp_router;
    localparam int NUM_S = 6;
    localparam int NUM_M = 2;
    localparam int ID_W  = 4;
    localparam int IDS_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_S*IDS_W-1:0] bid_s;
    logic [NUM_S*2-1:0]     bresp_s;
    logic [NUM_S-1:0]       bvalid_s;
    logic [NUM_S-1:0]       bready_s;
    logic [NUM_M*ID_W-1:0]  bid_m;
    logic [NUM_M*2-1:0]     bresp_m;
    logic [NUM_M-1:0]       bvalid_m;
    logic [NUM_M-1:0]       bready_m;
    logic                   unroutable;
`ifdef AXI_BRESP_ERRCNT_EN
    logic [15:0]            err_cnt;
`endif

    axi_bresp_router #(.NUM_S(NUM_S), .NUM_M(NUM_M), .ID_W(ID_W), .IDS_W(IDS_W)) dut (
        .clk(clk), .rst(rst),
        .bid_s(bid_s), .bresp_s(bresp_s), .bvalid_s(bvalid_s), .bready_s(bready_s),
        .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
        .unroutable(unroutable)
`ifdef AXI_BRESP_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    typedef struct {
        int              tgt;
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } rsp_t;

    rsp_t exp_q[$];
    int   grant_log[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic             sv_valid [NUM_S];
    logic [IDS_W-1:0] sv_bid   [NUM_S];
    logic [1:0]       sv_resp  [NUM_S];
    logic [NUM_S-1:0] hs;

    // Reference model: slice occupancy, round-robin pointer, pending pulse, error count.
    int m_rr = 0;
    int m_full = 0;
    int m_tgt = 0;
    bit m_unr = 1'b0;
    int m_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < NUM_S; k++) begin
            bvalid_s[k]                = sv_valid[k];
            bid_s[k*IDS_W +: IDS_W]    = sv_bid[k];
            bresp_s[k*2 +: 2]          = sv_resp[k];
        end
    endtask

    task automatic set_slave(input int k, input logic [IDS_W-1:0] id, input logic [1:0] r);
        sv_valid[k] = 1'b1;
        sv_bid[k]   = id;
        sv_resp[k]  = r;
    endtask

    task automatic model_reset();
        m_rr = 0; m_full = 0; m_tgt = 0; m_unr = 1'b0; m_err = 0;
        exp_q.delete();
        for (int k = 0; k < NUM_S; k++) sv_valid[k] = 1'b0;
        pack();
    endtask

    task automatic model_eval();
        int grant;
        int tag;
        int k;
        check("bvalid_m", 64'(bvalid_m), m_full ? 64'(1 << m_tgt) : 64'd0);
        check("unroutable", 64'(unroutable), 64'(m_unr));
`ifdef AXI_BRESP_ERRCNT_EN
        check("err_cnt", 64'(err_cnt), 64'(m_err));
`endif
        grant = -1;
        if (m_full == 0 || bready_m[m_tgt]) begin
            for (int i = 0; i < NUM_S; i++) begin
                k = (m_rr + i) % NUM_S;
                if (grant < 0 && sv_valid[k]) grant = k;
            end
        end
        check("bready_s", 64'(bready_s), (grant >= 0) ? 64'(1 << grant) : 64'd0);
        hs = bvalid_s & bready_s;
        for (int j = 0; j < NUM_S; j++) if (hs[j]) grant_log.push_back(j);

        if (m_full != 0 && bready_m[m_tgt]) m_full = 0;
        m_unr = 1'b0;
        if (grant >= 0) begin
            m_rr = (grant + 1) % NUM_S;
            tag  = int'(sv_bid[grant]) >> ID_W;
            if ($countones(tag) == 1 && tag < (1 << NUM_M)) begin
                m_full = 1;
                m_tgt  = $clog2(tag);
                exp_q.push_back('{m_tgt, sv_bid[grant][ID_W-1:0], sv_resp[grant]});
                if (sv_resp[grant][1]) m_err++;
            end else begin
                m_unr = 1'b1;
                m_err++;
            end
            if (m_err > 65535) m_err = 65535;
        end
    endtask

    task automatic tick();
        pack();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_S; k++) if (hs[k]) sv_valid[k] = 1'b0;
        pack();
    endtask

    task automatic drain_idle();
        int n;
        bit busy;
        bready_m = '1;
        n = 0;
        busy = 1'b1;
        while (busy && n < 60) begin
            tick();
            n++;
            busy = (m_full != 0) || (exp_q.size() != 0);
            for (int k = 0; k < NUM_S; k++) if (sv_valid[k]) busy = 1'b1;
        end
        n_vec++;
        if (busy) begin
            n_err++;
            $display("FAIL drain_timeout: got still busy after %0d cycles expected idle", n);
        end
    endtask

    // Monitor: compares every presented master response against the scoreboard front.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst && bvalid_m != '0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_bvalid: got bvalid_m=%b expected none", bvalid_m);
                end else begin
                    e = exp_q[0];
                    check("route", 64'(bvalid_m), 64'(1 << e.tgt));
                    check("bid_m", 64'(bid_m), 64'(e.id) << (e.tgt * ID_W));
                    check("bresp_m", 64'(bresp_m), 64'(e.resp) << (e.tgt * 2));
                    if (bready_m[e.tgt]) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int idx0;
        int rr_exp[6];
        int r;
        logic [3:0] tg;

        bready_m = '0;
        for (int k = 0; k < NUM_S; k++) begin
            sv_valid[k] = 1'b0; sv_bid[k] = '0; sv_resp[k] = '0;
        end
        pack();
        #23;
        check("rst_bvalid_m", 64'(bvalid_m), 64'd0);
        check("rst_bid_m", 64'(bid_m), 64'd0);
        check("rst_bresp_m", 64'(bresp_m), 64'd0);
        check("rst_unroutable", 64'(unroutable), 64'd0);
        check("rst_bready_s", 64'(bready_s), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // single response to master 1
        bready_m = 2'b10;
        set_slave(2, 8'h23, 2'b00);
        tick();
        drain_idle();

        // round robin among 0,3,5 (pointer sits at 3 after the previous grant of 2)
        rr_exp = '{3, 5, 0, 3, 5, 0};
        bready_m = 2'b11;
        idx0 = grant_log.size();
        for (int c = 0; c < 6; c++) begin
            if (!sv_valid[0]) set_slave(0, 8'h10 | 8'(c), 2'b00);
            if (!sv_valid[3]) set_slave(3, 8'h18 | 8'(c), 2'b01);
            if (!sv_valid[5]) set_slave(5, 8'h1C ^ 8'(c), 2'b00);
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            check("rr_order", 64'((idx0 + c < grant_log.size()) ? grant_log[idx0 + c] : -1), 64'(rr_exp[c]));
        end
        drain_idle();

        // stall on master 0 while slave 1 waits
        bready_m = 2'b00;
        set_slave(1, 8'h15, 2'b00);
        tick();
        set_slave(1, 8'h1A, 2'b01);
        for (int c = 0; c < 5; c++) tick();
        bready_m = 2'b01;
        tick();
        drain_idle();

        // unroutable tag
        set_slave(4, 8'h03, 2'b00);
        tick();
        drain_idle();

        // error response delivered unchanged
        bready_m = 2'b10;
        set_slave(0, 8'h2B, 2'b10);
        tick();
        drain_idle();

        // async reset with slice full and pointer at 3
        bready_m = 2'b00;
        set_slave(2, 8'h17, 2'b00);
        tick();
        rst = 1'b0;
        #1;
        check("arst_bvalid_m", 64'(bvalid_m), 64'd0);
        check("arst_bid_m", 64'(bid_m), 64'd0);
        model_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        bready_m = 2'b01;
        idx0 = grant_log.size();
        set_slave(4, 8'h14, 2'b00);
        set_slave(1, 8'h11, 2'b00);
        tick();
        tick();
        check("post_rst_first", 64'((idx0 < grant_log.size()) ? grant_log[idx0] : -1), 64'd1);
        check("post_rst_second", 64'((idx0 + 1 < grant_log.size()) ? grant_log[idx0 + 1] : -1), 64'd4);
        drain_idle();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NUM_S; k++) begin
                if (!sv_valid[k] && $urandom_range(0, 9) < 4) begin
                    r = $urandom_range(0, 9);
                    if (r < 4)       tg = 4'h1;
                    else if (r < 8)  tg = 4'h2;
                    else if (r == 8) tg = 4'h0;
                    else             tg = 4'($urandom_range(0, 15));
                    set_slave(k, {tg, 4'($urandom_range(0, 15))}, 2'($urandom_range(0, 3)));
                end
            end
            for (int m = 0; m < NUM_M; m++) bready_m[m] = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain_idle();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
